// File: rtl/uart_xcvr.sv
// Single-clock UART transceiver: baud counter in the clk domain, configurable framing,
// mid-bit sampling receiver with synchroniser, error flags and internal loopback.
module uart_xcvr #(
    parameter int CLK_FREQ     = 1000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loopback,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           PAR_EN    = (PARITY_EN != 0);
    localparam logic           PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t                tx_state_reg, tx_state_next;
    logic [CW-1:0]         tx_cnt_reg, tx_cnt_next;
    logic [3:0]            tx_idx_reg, tx_idx_next;
    logic [DATA_BITS-1:0]  tx_shift_reg, tx_shift_next;
    logic                  tx_par_reg, tx_par_next;
    logic                  tx_line;
    logic                  tx_tick;

    assign tx_tick  = (tx_cnt_reg == CNT_LAST);
    assign tx_ready = (tx_state_reg == S_IDLE);
    // The pin is held idle in loopback; the frame still travels on tx_line internally.
    assign tx       = loopback | tx_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_idx_reg   <= tx_idx_next;
            tx_shift_reg <= tx_shift_next;
            tx_par_reg   <= tx_par_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_idx_next   = tx_idx_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_line       = 1'b1;
        tx_done       = 1'b0;
        if (tx_state_reg != S_IDLE)
            tx_cnt_next = tx_tick ? '0 : tx_cnt_reg + 1'b1;
        case (tx_state_reg)
            S_IDLE: begin
                if (tx_valid) begin
                    tx_shift_next = tx_data;
                    tx_par_next   = (^tx_data) ^ PAR_ODD;
                    tx_cnt_next   = '0;
                    tx_state_next = S_START;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_tick) begin
                    tx_idx_next   = '0;
                    tx_state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx_line = tx_shift_reg[0];
                if (tx_tick) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_idx_reg == DATA_LAST) begin
                        tx_idx_next   = '0;
                        tx_state_next = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        tx_idx_next = tx_idx_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                tx_line = tx_par_reg;
                if (tx_tick) begin
                    tx_idx_next   = '0;
                    tx_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_tick) begin
                    if (tx_idx_reg == STOP_LAST) begin
                        tx_done       = 1'b1;
                        tx_state_next = S_IDLE;
                    end else begin
                        tx_idx_next = tx_idx_reg + 1'b1;
                    end
                end
            end
            default: tx_state_next = S_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    state_t                rx_state_reg, rx_state_next;
    logic [CW-1:0]         rx_cnt_reg, rx_cnt_next;
    logic [3:0]            rx_idx_reg, rx_idx_next;
    logic [DATA_BITS-1:0]  rx_shift_reg, rx_shift_next;
    logic                  rx_perr_pend_reg, rx_perr_pend_next;
    logic                  rx_ferr_pend_reg, rx_ferr_pend_next;
    logic [DATA_BITS-1:0]  rx_data_reg, rx_data_next;
    logic                  rx_valid_reg, rx_valid_next;
    logic                  rx_perr_reg, rx_perr_next;
    logic                  rx_ferr_reg, rx_ferr_next;
    logic                  rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic                  rx_tick;

    assign rx_tick       = (rx_cnt_reg == CNT_LAST);
    assign rx_data       = rx_data_reg;
    assign rx_valid      = rx_valid_reg;
    assign rx_parity_err = rx_perr_reg;
    assign rx_frame_err  = rx_ferr_reg;
    assign rx_busy       = (rx_state_reg != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg      <= 1'b1;
            rx_sync_reg      <= 1'b1;
            rx_prev_reg      <= 1'b1;
            rx_state_reg     <= S_IDLE;
            rx_cnt_reg       <= '0;
            rx_idx_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_perr_pend_reg <= 1'b0;
            rx_ferr_pend_reg <= 1'b0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rx_perr_reg      <= 1'b0;
            rx_ferr_reg      <= 1'b0;
        end else begin
            rx_meta_reg      <= loopback ? tx_line : rx;
            rx_sync_reg      <= rx_meta_reg;
            rx_prev_reg      <= rx_sync_reg;
            rx_state_reg     <= rx_state_next;
            rx_cnt_reg       <= rx_cnt_next;
            rx_idx_reg       <= rx_idx_next;
            rx_shift_reg     <= rx_shift_next;
            rx_perr_pend_reg <= rx_perr_pend_next;
            rx_ferr_pend_reg <= rx_ferr_pend_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            rx_perr_reg      <= rx_perr_next;
            rx_ferr_reg      <= rx_ferr_next;
        end
    end

    always_comb begin
        rx_state_next     = rx_state_reg;
        rx_cnt_next       = rx_cnt_reg;
        rx_idx_next       = rx_idx_reg;
        rx_shift_next     = rx_shift_reg;
        rx_perr_pend_next = rx_perr_pend_reg;
        rx_ferr_pend_next = rx_ferr_pend_reg;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        rx_perr_next      = rx_perr_reg;
        rx_ferr_next      = rx_ferr_reg;
        if (rx_state_reg != S_IDLE)
            rx_cnt_next = rx_tick ? '0 : rx_cnt_reg + 1'b1;
        case (rx_state_reg)
            S_IDLE: begin
                // Edge-triggered start: a line held low after a break never re-arms until it rises.
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_cnt_next       = '0;
                    rx_perr_pend_next = 1'b0;
                    rx_ferr_pend_next = 1'b0;
                    rx_state_next     = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_reg == CNT_HALF) begin
                    rx_cnt_next   = '0;
                    rx_idx_next   = '0;
                    rx_state_next = rx_sync_reg ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_idx_reg == DATA_LAST) begin
                        rx_idx_next   = '0;
                        rx_state_next = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_idx_next = rx_idx_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_tick) begin
                    rx_perr_pend_next = (^rx_shift_reg) ^ PAR_ODD ^ rx_sync_reg;
                    rx_idx_next       = '0;
                    rx_state_next     = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    rx_ferr_pend_next = rx_ferr_pend_reg | ~rx_sync_reg;
                    if (rx_idx_reg == STOP_LAST) begin
                        rx_data_next  = rx_shift_reg;
                        rx_valid_next = 1'b1;
                        rx_perr_next  = rx_perr_pend_reg;
                        rx_ferr_next  = rx_ferr_pend_reg | ~rx_sync_reg;
                        rx_state_next = S_IDLE;
                    end else begin
                        rx_idx_next = rx_idx_reg + 1'b1;
                    end
                end
            end
            default: rx_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: 8N1 loopback, 8E1 external rx, 7O2 with tx wired to rx.
module tb_uart_xcvr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_loopback, a_tx_valid, a_tx_ready, a_tx, a_tx_done, a_rx;
    logic [7:0] a_tx_data, a_rx_data;
    logic       a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_busy;
    logic       b_loopback, b_tx_valid, b_tx_ready, b_tx, b_tx_done, b_rx;
    logic [7:0] b_tx_data, b_rx_data;
    logic       b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_busy;
    logic       c_loopback, c_tx_valid, c_tx_ready, c_tx, c_tx_done;
    logic [6:0] c_tx_data, c_rx_data;
    logic       c_rx_valid, c_rx_perr, c_rx_ferr, c_rx_busy;

    uart_xcvr #(.CLKS_PER_BIT(16)) u_8n1 (
        .clk(clk), .rst(rst), .loopback(a_loopback), .tx_valid(a_tx_valid),
        .tx_data(a_tx_data), .tx_ready(a_tx_ready), .tx(a_tx), .tx_done(a_tx_done),
        .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .rx_parity_err(a_rx_perr), .rx_frame_err(a_rx_ferr), .rx_busy(a_rx_busy));

    uart_xcvr #(.CLKS_PER_BIT(16), .PARITY_EN(1)) u_8e1 (
        .clk(clk), .rst(rst), .loopback(b_loopback), .tx_valid(b_tx_valid),
        .tx_data(b_tx_data), .tx_ready(b_tx_ready), .tx(b_tx), .tx_done(b_tx_done),
        .rx(b_rx), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .rx_parity_err(b_rx_perr), .rx_frame_err(b_rx_ferr), .rx_busy(b_rx_busy));

    uart_xcvr #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
                .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .loopback(c_loopback), .tx_valid(c_tx_valid),
        .tx_data(c_tx_data), .tx_ready(c_tx_ready), .tx(c_tx), .tx_done(c_tx_done),
        .rx(c_tx), .rx_data(c_rx_data), .rx_valid(c_rx_valid),
        .rx_parity_err(c_rx_perr), .rx_frame_err(c_rx_ferr), .rx_busy(c_rx_busy));

    int n_checks = 0;
    int n_fail   = 0;
    int a_nrx = 0, b_nrx = 0, c_nrx = 0;

    always @(posedge clk) begin
        if (a_rx_valid) a_nrx <= a_nrx + 1;
        if (b_rx_valid) b_nrx <= b_nrx + 1;
        if (c_rx_valid) c_nrx <= c_nrx + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Drive one frame on b_rx: start, 8 data LSB first, parity, stop; 16 clocks per bit.
    task automatic b_send(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            b_rx = bits[k];
            repeat (16) @(negedge clk);
        end
        b_rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, n0;
        logic        pin_low;
        logic [10:0] exp_wave;

        a_loopback = 0; a_tx_valid = 0; a_tx_data = '0; a_rx = 1'b1;
        b_loopback = 0; b_tx_valid = 0; b_tx_data = '0; b_rx = 1'b1;
        c_loopback = 0; c_tx_valid = 0; c_tx_data = '0;
        repeat (3) @(negedge clk);

        check("rst_tx",       a_tx, 1);
        check("rst_tx_ready", a_tx_ready, 1);
        check("rst_tx_done",  a_tx_done, 0);
        check("rst_rx_busy",  b_rx_busy, 0);
        check("rst_rx_valid", b_rx_valid, 0);
        check("rst_rx_data",  b_rx_data, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: 8N1 loopback, A5
        a_loopback = 1'b1;
        repeat (4) @(negedge clk);
        n0 = a_nrx;
        a_tx_data = 8'hA5; a_tx_valid = 1'b1;
        pin_low = 1'b0;
        @(posedge clk); n = 1;
        @(negedge clk);
        a_tx_valid = 1'b0; a_tx_data = 8'h00;
        check("t1_ready_drop", a_tx_ready, 0);
        while (!a_tx_done && n < 400) begin
            if (!a_tx) pin_low = 1'b1;
            @(posedge clk); n++;
            @(negedge clk);
        end
        check("t1_txdone_clocks", n, 160);
        check("t1_pin_stays_high", pin_low, 0);
        check("t1_rx_count", a_nrx, n0 + 1);
        check("t1_rx_data", a_rx_data, 8'hA5);
        check("t1_perr", a_rx_perr, 0);
        check("t1_ferr", a_rx_ferr, 0);
        @(negedge clk);
        check("t1_ready_back", a_tx_ready, 1);
        a_loopback = 1'b0;

        // 2: 8E1 external, parity good then bad
        n0 = b_nrx;
        b_send(8'h3C, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t2_rx_count", b_nrx, n0 + 1);
        check("t2_rx_data", b_rx_data, 8'h3C);
        check("t2_perr_good", b_rx_perr, 0);
        check("t2_ferr_good", b_rx_ferr, 0);
        b_send(8'h3C, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t2_rx_count2", b_nrx, n0 + 2);
        check("t2_rx_data_bad", b_rx_data, 8'h3C);
        check("t2_perr_bad", b_rx_perr, 1);

        // 3: stop bit low, then break for 3 frames
        b_send(8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_ferr_stop0", b_rx_ferr, 1);
        check("t3_perr_stop0", b_rx_perr, 0);
        n0 = b_nrx;
        b_rx = 1'b0;
        repeat (3 * 11 * 16) @(negedge clk);
        check("t3_break_once", b_nrx, n0 + 1);
        check("t3_break_ferr", b_rx_ferr, 1);
        check("t3_break_data", b_rx_data, 8'h00);
        b_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t3_break_no_more", b_nrx, n0 + 1);
        check("t3_break_idle", b_rx_busy, 0);
        b_send(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t3_recover_count", b_nrx, n0 + 2);
        check("t3_recover_data", b_rx_data, 8'hA5);
        check("t3_recover_ferr", b_rx_ferr, 0);

        // 4: 4-clock glitch is a false start
        n0 = b_nrx;
        b_rx = 1'b0;
        repeat (4) @(negedge clk);
        b_rx = 1'b1;
        check("t4_busy_during", b_rx_busy, 1);
        repeat (20) @(negedge clk);
        check("t4_busy_after", b_rx_busy, 0);
        check("t4_no_valid", b_nrx, n0);

        // 5: 7O2 waveform for 55, tx_valid held -> back-to-back frames
        n0 = c_nrx;
        exp_wave = 11'b11110101010;
        c_tx_data = 7'h55; c_tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("t5_bit%0d_first", k), c_tx, exp_wave[k]);
            repeat (15) @(negedge clk);
            check($sformatf("t5_bit%0d_last", k), c_tx, exp_wave[k]);
            if (k == 10) check("t5_tx_done", c_tx_done, 1);
            @(negedge clk);
        end
        check("t5_idle_gap_tx", c_tx, 1);
        check("t5_idle_gap_ready", c_tx_ready, 1);
        @(negedge clk);
        check("t5_b2b_start", c_tx, 0);
        check("t5_b2b_ready", c_tx_ready, 0);
        c_tx_valid = 1'b0;
        check("t5_rx_count", c_nrx, n0 + 1);
        check("t5_rx_data", c_rx_data, 7'h55);
        check("t5_rx_perr", c_rx_perr, 0);
        check("t5_rx_ferr", c_rx_ferr, 0);

        // 6: reset in the middle of the second frame's data bits
        repeat (40) @(negedge clk);
        n0 = c_nrx;
        check("t6_busy_before", c_rx_busy, 1);
        rst = 1'b0;
        #1;
        check("t6_rst_tx", c_tx, 1);
        check("t6_rst_ready", c_tx_ready, 1);
        check("t6_rst_rx_busy", c_rx_busy, 0);
        check("t6_rst_rx_data", c_rx_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_rx_valid", c_nrx, n0);
        c_tx_data = 7'h2A; c_tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_tx_valid = 1'b0;
        n = 0;
        while (!c_tx_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t6_tx_len", n, 175);
        repeat (3) @(negedge clk);
        check("t6_rx_count", c_nrx, n0 + 1);
        check("t6_rx_data", c_rx_data, 7'h2A);
        check("t6_rx_perr", c_rx_perr, 0);
        check("t6_rx_ferr", c_rx_ferr, 0);
        check("t6_ready", c_tx_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
